// File: rtl/disp_mode_arbiter_if.sv
// Pin-side bundle of the display/mode arbiter: button, alarm ring/ack, three digit sources, scan outputs.
interface disp_mode_arbiter_if;
  logic        mode_btn;
  logic        alarm_ring;
  logic        alarm_ack;
  logic [31:0] watch_bcd;
  logic [31:0] stop_bcd;
  logic [31:0] alarm_bcd;
  logic [7:0]  watch_dp;
  logic [7:0]  stop_dp;
  logic [7:0]  alarm_dp;
  logic [1:0]  mode_state;
  logic        ring_active;
  logic [7:0]  seg_data;
  logic [7:0]  seg_com;

  modport master (
    output mode_btn, alarm_ring, alarm_ack,
    output watch_bcd, stop_bcd, alarm_bcd, watch_dp, stop_dp, alarm_dp,
    input  mode_state, ring_active, seg_data, seg_com
  );

  modport slave (
    input  mode_btn, alarm_ring, alarm_ack,
    input  watch_bcd, stop_bcd, alarm_bcd, watch_dp, stop_dp, alarm_dp,
    output mode_state, ring_active, seg_data, seg_com
  );
endinterface

// File: rtl/disp_mode_arbiter.sv
// Mode FSM with debounced button, alarm-ring preemption and 8-digit multiplexed 7-segment scan.
// Button press reaches the mode 2+DEBOUNCE_CYC cycles after the raw edge; segment outputs are registered.
module disp_mode_arbiter #(
  parameter int DEBOUNCE_CYC = 20,
  parameter int SCAN_DIV     = 1,
  parameter int BLINK_CYC    = 250
) (
  input logic clk,
  input logic rst,
  disp_mode_arbiter_if.slave bus
);
  localparam int BLANK_LEN = 8 * SCAN_DIV;
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam int BLW = $clog2(BLANK_LEN + 1);
  localparam int BKW = $clog2(BLINK_CYC + 1);

  typedef enum logic [1:0] {
    S_WATCH = 2'b00,
    S_STOP  = 2'b01,
    S_ALARM = 2'b10,
    S_RING  = 2'b11
  } state_t;

  state_t           state, saved, nxt;
  logic             btn_s1, btn_s2, deb, deb_d;
  logic [DBW-1:0]   deb_cnt;
  logic             ring_r, ring_r2;
  logic             mode_pulse, ring_req, chg;
  logic [2:0]       scan_idx;
  logic [SCW-1:0]   scan_cnt;
  logic [BLW-1:0]   blank_cnt;
  logic [BKW-1:0]   blink_cnt;
  logic             blink_on;
  logic             ring_active_r;
  logic [7:0]       seg_data_r, seg_com_r;
  logic [31:0]      bcd_sel;
  logic [7:0]       dp_sel;
  logic [3:0]       nib;
  logic             lit;
  logic [7:0]       lit_com, lit_data;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h40;
      default: decode = 7'h00;
    endcase
  endfunction

  assign mode_pulse = deb & ~deb_d;
  assign ring_req   = ring_r & ~ring_r2;

  // Ring entry beats a coincident mode pulse; in ring, ack and pulse are one exit.
  always_comb begin
    nxt = state;
    if (state == S_RING) begin
      if (bus.alarm_ack || mode_pulse) nxt = saved;
    end else if (ring_req) begin
      nxt = S_RING;
    end else if (mode_pulse) begin
      case (state)
        S_WATCH: nxt = S_STOP;
        S_STOP:  nxt = S_ALARM;
        default: nxt = S_WATCH;
      endcase
    end
  end

  assign chg = (nxt != state);

  always_comb begin
    case (state)
      S_WATCH: begin bcd_sel = bus.watch_bcd; dp_sel = bus.watch_dp; end
      S_STOP:  begin bcd_sel = bus.stop_bcd;  dp_sel = bus.stop_dp;  end
      default: begin bcd_sel = bus.alarm_bcd; dp_sel = bus.alarm_dp; end
    endcase
  end

  assign nib      = bcd_sel[{scan_idx, 2'b00} +: 4];
  assign lit      = (state != S_RING) || blink_on;
  assign lit_com  = ~(8'b1 << scan_idx);
  assign lit_data = {dp_sel[scan_idx], decode(nib)};

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1        <= 1'b0;
      btn_s2        <= 1'b0;
      deb           <= 1'b0;
      deb_d         <= 1'b0;
      deb_cnt       <= '0;
      ring_r        <= 1'b0;
      ring_r2       <= 1'b0;
      state         <= S_WATCH;
      saved         <= S_WATCH;
      ring_active_r <= 1'b0;
      scan_idx      <= '0;
      scan_cnt      <= '0;
      blank_cnt     <= '0;
      blink_cnt     <= '0;
      blink_on      <= 1'b1;
      seg_data_r    <= 8'h00;
      seg_com_r     <= 8'hFF;
    end else begin
      btn_s1  <= bus.mode_btn;
      btn_s2  <= btn_s1;
      deb_d   <= deb;
      ring_r  <= bus.alarm_ring;
      ring_r2 <= ring_r;
      if (btn_s2 != deb) begin
        if (deb_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
          deb     <= btn_s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end

      state         <= nxt;
      ring_active_r <= (nxt == S_RING);
      if (state != S_RING && ring_req) saved <= state;

      // Blank frame counts up to BLANK_LEN; reset leaves it at 0 so power-up also blanks one frame.
      if (chg) begin
        blank_cnt  <= BLW'(1);
        scan_idx   <= '0;
        scan_cnt   <= '0;
        seg_com_r  <= 8'hFF;
        seg_data_r <= 8'h00;
        if (nxt == S_RING) begin
          blink_cnt <= '0;
          blink_on  <= 1'b1;
        end
      end else if (blank_cnt != BLW'(BLANK_LEN)) begin
        blank_cnt  <= blank_cnt + 1'b1;
        seg_com_r  <= 8'hFF;
        seg_data_r <= 8'h00;
      end else begin
        seg_com_r  <= lit ? lit_com : 8'hFF;
        seg_data_r <= lit ? lit_data : 8'h00;
        if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
          scan_cnt <= '0;
          scan_idx <= scan_idx + 1'b1;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
        if (state == S_RING) begin
          if (blink_cnt == BKW'(BLINK_CYC - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.mode_state  = state;
  assign bus.ring_active = ring_active_r;
  assign bus.seg_data    = seg_data_r;
  assign bus.seg_com     = seg_com_r;
endmodule

// File: tb/tb_disp_mode_arbiter.sv
// Bench for disp_mode_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_disp_mode_arbiter;
  localparam int DEB   = 20;
  localparam int SD    = 1;
  localparam int BLINK = 250;
  localparam int BLANK = 8 * SD;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  disp_mode_arbiter_if bus ();

  disp_mode_arbiter #(.DEBOUNCE_CYC(DEB), .SCAN_DIV(SD), .BLINK_CYC(BLINK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: tracks elapsed cycles and sample history rather than hardware counters.
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  logic m_h0, m_h1, m_deb, m_rose, m_r1, m_r2;
  int   m_run, m_state, m_saved, m_blank_left, m_scan_ticks, m_ring_ticks;
  logic [7:0] m_com, m_data;
  logic [1:0] m_mode;
  logic       m_ringact;

  always @(posedge clk) begin : model
    int nxt, dig;
    logic pulse, req, on;
    logic [31:0] bcd;
    logic [7:0]  dp;
    logic [3:0]  nibv;
    if (rst) begin
      m_h0 = 0; m_h1 = 0; m_deb = 0; m_rose = 0; m_r1 = 0; m_r2 = 0; m_run = 0;
      m_state = 0; m_saved = 0; m_blank_left = BLANK; m_scan_ticks = 0; m_ring_ticks = 0;
      m_com = 8'hFF; m_data = 8'h00;
    end else begin
      pulse = m_rose;
      req   = m_r1 && !m_r2;
      m_rose = 0;
      if (m_h1 != m_deb) begin
        m_run++;
        if (m_run == DEB) begin m_deb = m_h1; m_run = 0; m_rose = m_h1; end
      end else m_run = 0;
      m_h1 = m_h0; m_h0 = bus.mode_btn;
      m_r2 = m_r1; m_r1 = bus.alarm_ring;

      nxt = m_state;
      if (m_state == 3) begin
        if (bus.alarm_ack || pulse) nxt = m_saved;
      end else if (req) begin
        nxt = 3; m_saved = m_state;
      end else if (pulse) nxt = (m_state + 1) % 3;

      if (nxt != m_state) begin
        m_com = 8'hFF; m_data = 8'h00;
        m_blank_left = BLANK - 1; m_scan_ticks = 0;
        if (nxt == 3) m_ring_ticks = 0;
      end else if (m_blank_left > 0) begin
        m_com = 8'hFF; m_data = 8'h00;
        m_blank_left--;
      end else begin
        dig = (m_scan_ticks / SD) % 8;
        on  = (m_state != 3) || ((m_ring_ticks / BLINK) % 2 == 0);
        case (m_state)
          0: begin bcd = bus.watch_bcd; dp = bus.watch_dp; end
          1: begin bcd = bus.stop_bcd;  dp = bus.stop_dp;  end
          default: begin bcd = bus.alarm_bcd; dp = bus.alarm_dp; end
        endcase
        nibv   = bcd[dig*4 +: 4];
        m_com  = on ? ~(8'h01 << dig) : 8'hFF;
        m_data = on ? {dp[dig], lut[nibv]} : 8'h00;
        m_scan_ticks++;
        if (m_state == 3) m_ring_ticks++;
      end
      m_state = nxt;
    end
    m_mode    = 2'(m_state);
    m_ringact = (m_state == 3);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.watch_bcd = 32'h1234_5678; bus.watch_dp = 8'h00;
    tick(13);
    rst = 1'b1; tick(3); rst = 1'b0;
    checks++;
    if (bus.mode_state !== 2'b00 || bus.ring_active !== 1'b0 || bus.seg_com !== 8'hFF || bus.seg_data !== 8'h00) begin
      errors++; $display("FAIL reset_state: mode=%b ring=%b com=%h data=%h, want 00 0 FF 00", bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data);
    end
    for (int i = 0; i < BLANK; i++) begin
      tick(1); checks++;
      if (bus.seg_com !== 8'hFF || bus.seg_data !== 8'h00) begin
        errors++; $display("FAIL reset_blank[%0d]: com=%h data=%h, want FF 00", i, bus.seg_com, bus.seg_data);
      end
    end
    tick(1); checks++;
    if (bus.seg_com !== 8'hFE || bus.seg_data !== 8'h7F) begin
      errors++; $display("FAIL reset_resume: com=%h data=%h, want FE 7F", bus.seg_com, bus.seg_data);
    end
  endtask

  task automatic test_scan;
    logic [7:0] exp_seg [8] = '{8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};
    logic [7:0] ecom;
    for (int i = 1; i <= 16; i++) begin
      tick(1); checks++;
      ecom = ~(8'h01 << (i % 8));
      if (bus.seg_com !== ecom || bus.seg_data !== exp_seg[i % 8]) begin
        errors++; $display("FAIL scan_digit[%0d]: com=%h data=%h, want %h %h", i, bus.seg_com, bus.seg_data, ecom, exp_seg[i % 8]);
      end
    end
    bus.watch_bcd = $urandom; bus.watch_dp = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      tick(1); checks++;
      if ({bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data} !== {m_mode, m_ringact, m_com, m_data}) begin
        errors++; $display("FAIL scan_model cyc %0d: got %b/%b/%h/%h want %b/%b/%h/%h", cyc, bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data, m_mode, m_ringact, m_com, m_data);
      end
    end
  endtask

  task automatic test_debounce;
    int k, nb;
    for (int i = 0; i < 40; i++) begin
      bus.mode_btn = ((i / 5) % 2 == 0);
      tick(1); checks++;
      if ({bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data} !== {m_mode, m_ringact, m_com, m_data}) begin
        errors++; $display("FAIL bounce_model cyc %0d: got %b/%h/%h want %b/%h/%h", cyc, bus.mode_state, bus.seg_com, bus.seg_data, m_mode, m_com, m_data);
      end
    end
    checks++;
    if (bus.mode_state !== 2'b00) begin
      errors++; $display("FAIL bounce_no_change: mode=%b, want 00", bus.mode_state);
    end
    bus.mode_btn = 1'b1;
    tick(1);
    k = 0;
    while (bus.mode_state === 2'b00 && k < 40) begin tick(1); k++; end
    checks++;
    if (bus.mode_state !== 2'b01 || k != DEB + 2) begin
      errors++; $display("FAIL press_latency: mode=%b after %0d cycles, want 01 after %0d", bus.mode_state, k, DEB + 2);
    end
    nb = 0;
    while (bus.seg_com === 8'hFF && nb < 20) begin nb++; tick(1); end
    checks++;
    if (nb != BLANK || bus.seg_com !== 8'hFE) begin
      errors++; $display("FAIL mode_blank: %0d blank cycles then com=%h, want %0d then FE", nb, bus.seg_com, BLANK);
    end
    bus.mode_btn = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1); checks++;
      if ({bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data} !== {m_mode, m_ringact, m_com, m_data}) begin
        errors++; $display("FAIL release_model cyc %0d: got %b/%h/%h want %b/%h/%h", cyc, bus.mode_state, bus.seg_com, bus.seg_data, m_mode, m_com, m_data);
      end
    end
  endtask

  task automatic test_ring_preempt;
    int k;
    bus.mode_btn = 1'b1;
    tick(DEB + 1);
    bus.alarm_ring = 1'b1;
    tick(2);
    checks++;
    if (bus.mode_state !== 2'b11 || bus.ring_active !== 1'b1) begin
      errors++; $display("FAIL ring_wins: mode=%b ring=%b, want 11 1", bus.mode_state, bus.ring_active);
    end
    bus.mode_btn = 1'b0;
    tick(1);
    bus.alarm_ack = 1'b1; tick(1); bus.alarm_ack = 1'b0;
    checks++;
    if (bus.mode_state !== 2'b01 || bus.ring_active !== 1'b0) begin
      errors++; $display("FAIL ack_return: mode=%b ring=%b, want 01 0", bus.mode_state, bus.ring_active);
    end
    for (int i = 0; i < 50; i++) begin
      tick(1); checks++;
      if ({bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data} !== {m_mode, m_ringact, m_com, m_data}) begin
        errors++; $display("FAIL held_ring_model cyc %0d: got %b/%b/%h/%h want %b/%b/%h/%h", cyc, bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data, m_mode, m_ringact, m_com, m_data);
      end
    end
    checks++;
    if (bus.mode_state !== 2'b01) begin
      errors++; $display("FAIL held_no_retrigger: mode=%b, want 01", bus.mode_state);
    end
    bus.alarm_ring = 1'b0; tick(3); bus.alarm_ring = 1'b1; tick(2);
    checks++;
    if (bus.mode_state !== 2'b11) begin
      errors++; $display("FAIL ring_reenter: mode=%b, want 11", bus.mode_state);
    end
    bus.mode_btn = 1'b1;
    k = 0;
    while (bus.mode_state === 2'b11 && k < 40) begin tick(1); k++; end
    checks++;
    if (bus.mode_state !== 2'b01 || k != DEB + 3) begin
      errors++; $display("FAIL btn_exit: mode=%b after %0d cycles, want 01 after %0d", bus.mode_state, k, DEB + 3);
    end
    bus.mode_btn = 1'b0; bus.alarm_ring = 1'b0;
    tick(30);
    checks++;
    if ({bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data} !== {m_mode, m_ringact, m_com, m_data}) begin
      errors++; $display("FAIL preempt_model: got %b/%b/%h/%h want %b/%b/%h/%h", bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data, m_mode, m_ringact, m_com, m_data);
    end
  endtask

  task automatic test_ring_blink;
    logic blank_exp;
    bus.alarm_bcd = 32'hAAAA_AAAA; bus.alarm_dp = 8'h00;
    bus.alarm_ring = 1'b1;
    tick(2);
    for (int i = 0; i < 600; i++) begin
      blank_exp = (i < BLANK) || (i >= BLANK + BLINK && i < BLANK + 2 * BLINK);
      checks++;
      if (bus.ring_active !== 1'b1 ||
          (blank_exp && (bus.seg_com !== 8'hFF || bus.seg_data !== 8'h00)) ||
          (!blank_exp && (bus.seg_com === 8'hFF || bus.seg_data !== 8'h40))) begin
        errors++; $display("FAIL blink_phase[%0d]: ring=%b com=%h data=%h, want blank=%b", i, bus.ring_active, bus.seg_com, bus.seg_data, blank_exp);
      end
      checks++;
      if ({bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data} !== {m_mode, m_ringact, m_com, m_data}) begin
        errors++; $display("FAIL blink_model cyc %0d: got %b/%h/%h want %b/%h/%h", cyc, bus.mode_state, bus.seg_com, bus.seg_data, m_mode, m_com, m_data);
      end
      tick(1);
    end
    bus.alarm_ack = 1'b1; tick(1); bus.alarm_ack = 1'b0; bus.alarm_ring = 1'b0;
    checks++;
    if (bus.mode_state !== 2'b01) begin
      errors++; $display("FAIL blink_exit: mode=%b, want 01", bus.mode_state);
    end
    tick(5);
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29, 0) == 0) bus.mode_btn = ~bus.mode_btn;
      if ($urandom_range(99, 0) == 0) bus.alarm_ring = ~bus.alarm_ring;
      bus.alarm_ack = ($urandom_range(59, 0) == 0);
      if ((i % 64) == 0) begin
        bus.watch_bcd = $urandom; bus.stop_bcd = $urandom; bus.alarm_bcd = $urandom;
        bus.watch_dp = 8'($urandom); bus.stop_dp = 8'($urandom); bus.alarm_dp = 8'($urandom);
      end
      tick(1); checks++;
      if ({bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data} !== {m_mode, m_ringact, m_com, m_data}) begin
        errors++; $display("FAIL random_model cyc %0d: got %b/%b/%h/%h want %b/%b/%h/%h", cyc, bus.mode_state, bus.ring_active, bus.seg_com, bus.seg_data, m_mode, m_ringact, m_com, m_data);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.mode_btn = 1'b0; bus.alarm_ring = 1'b0; bus.alarm_ack = 1'b0;
    bus.watch_bcd = '0; bus.stop_bcd = '0; bus.alarm_bcd = '0;
    bus.watch_dp = '0; bus.stop_dp = '0; bus.alarm_dp = '0;
    tick(3);
    rst = 1'b0;
    test_reset;
    test_scan;
    test_debounce;
    test_ring_preempt;
    test_ring_blink;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/disp_mode_arbiter.md
Name: disp_mode_arbiter

Overview:
- Owns the shared 8-digit 7-segment display and the mode sequence for the watch / stopwatch / alarm-set functions.
- Debounces the raw mode button and advances the function state machine.
- Lets an alarm-ring request preempt the display, then selects one source's packed-BCD digits and drives the multiplexed digit scan.
- Sits between the function blocks and the board pins, at 1 kHz.

Parameters:
DEBOUNCE_CYC, 20, consecutive stable cycles needed to accept a new button level
SCAN_DIV, 1, clock cycles each digit stays lit
BLINK_CYC, 250, cycles per half-period of the ring flash

Ports:
clk  in  1  system clock (1 kHz)
rst  in  1  synchronous active-high reset
mode_btn  in  1  raw mode push-button, asynchronous
alarm_ring  in  1  ring request level from the alarm block
alarm_ack  in  1  ring dismiss, synchronous, one cycle or longer
watch_bcd  in  32  8 BCD nibbles; [3:0] = digit 0 (rightmost)
stop_bcd  in  32  stopwatch digits, same packing
alarm_bcd  in  32  alarm-set digits, same packing
watch_dp, stop_dp, alarm_dp  in  8 each  decimal-point mask per digit
mode_state  out  2  00 watch, 01 stopwatch, 10 alarm-set, 11 ring
ring_active  out  1  high while in ring state
seg_data  out  8  {dp,g,f,e,d,c,b,a}, active-high
seg_com  out  8  digit enables, active-low one-hot

Behaviour:
- Reset: synchronous on rst high at posedge clk, overrides everything.
  - State S_WATCH, mode_state=00, ring_active=0.
  - seg_data=8'h00, seg_com=8'hFF.
  - Scan index 0, blink phase on, debounced level 0, saved mode 00.
  - All counters 0; blank-frame flag clear.
- Button path: 2-flop synchronizer, then debounce.
  - Debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles.
  - Any bounce restarts the count.
  - A 0->1 change of the debounced level gives a one-cycle mode_pulse.
  - Total press latency from raw edge: 2+DEBOUNCE_CYC cycles.
- Ring request: ring_req = rising edge of registered alarm_ring. A held level does not retrigger.
- FSM transitions on mode_pulse:
  - S_WATCH->S_STOP, S_STOP->S_ALARM, S_ALARM->S_WATCH.
- Preemption:
  - ring_req in S_WATCH, S_STOP or S_ALARM -> S_RING; save the current state.
  - ring_req and mode_pulse in the same cycle: ring wins; saved mode = pre-pulse state; the pulse is discarded.
- In S_RING:
  - alarm_ack or mode_pulse -> return to the saved state. The pulse does not also advance the mode.
  - ring_req is ignored.
  - Simultaneous ack and pulse count as a single exit.
- Source select: watch in S_WATCH, stop in S_STOP, alarm in S_ALARM and S_RING. mode_state and ring_active are registered and reflect the state directly.
- Scan:
  - Index 0..7 advances every SCAN_DIV cycles and wraps 7->0.
  - Outputs are registered one cycle after the index: seg_com bit i low for digit i, seg_data = decode(nibble i) with bit7 = dp[i].
- Decode:
  - 0-9: standard segments (0 -> 8'h3F, 8 -> 8'h7F).
  - 4'hA: '-' (8'h40).
  - 4'hB-4'hF: blank (segments 0; dp still honoured).
- Blanking on any state change, including ring entry/exit:
  - Scan index resets to 0.
  - seg_com=FF and seg_data=00 for exactly 8*SCAN_DIV cycles.
  - Scanning then resumes at digit 0.
  - A further change during blanking restarts the blank frame.
- Ring flash:
  - Blink counter runs only in S_RING. Phase toggles every BLINK_CYC cycles; the first off phase starts after the blank frame plus BLINK_CYC cycles.
  - Off phase: seg_com=FF, seg_data=00.
  - Counter and phase reset to 0/on on ring entry.
- Source inputs are sampled live every cycle; no handshake with the function blocks.

Test Plan:
- rst high 3 cycles mid-scan -> next cycle mode_state=00, seg_com=FF, seg_data=00; after 8 blank cycles, digit 0 scan resumes with seg_com=FE.
- watch_bcd=32'h1234_5678, watch_dp=0 -> successive cycles give seg_com FE,FD..7F with seg_data 7F(8),07(7),7D(6),6D(5),66(4),4F(3),5B(2),06(1), then wrap to FE.
- mode_btn bounces 0/1 every 5 cycles for 40 cycles, then holds high 25 cycles -> exactly one transition 00->01, occurring 22 cycles after the stable high begins; display blank for 8 cycles.
- In S_STOP, alarm_ring rises in the same cycle as mode_pulse -> mode_state=11, ring_active=1; alarm_ack -> back to 01, not 10.
- In S_RING with alarm_bcd=32'hAAAA_AAAA, hold 600 cycles -> segments show 40 while on; after 8 blank + 250 cycles seg_com=FF for 250 cycles, then scanning resumes.
- alarm_ring held high after ack -> remains in saved mode; deassert then reassert -> re-enters S_RING.
